// File: rtl/mac_dot.sv
// mac_dot: signed LEN-element dot product (start; a/b in_valid/in_ready in; res/sat out_valid/out_ready out; busy)
module mac_dot #(
  parameter int DW = 8,
  parameter int ACCW = 26,
  parameter int LEN = 8,
  parameter int SHIFT = 0,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] res,
  output logic          sat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  localparam int CW = LEN > 1 ? $clog2(LEN) : 1;
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic signed [2*DW-1:0] prod;
  logic prod_v;
  logic signed [ACCW-1:0] acc, t;
  logic accept, last;
  always_comb begin
    in_ready = state == ACCUM;
    out_valid = state == DONE;
    busy = state != IDLE;
    accept = in_valid && in_ready;
    last = accept && cnt == CW'(LEN - 1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ACCUM : IDLE;
      ACCUM:   state_nx = last ? DRAIN : ACCUM;
      DRAIN:   state_nx = DONE;
      default: state_nx = out_ready ? IDLE : DONE;
    endcase
    t = acc >>> SHIFT;
    sat = t > MAXV || t < MINV;
    res = t > MAXV ? MAXV[OW-1:0] : t < MINV ? MINV[OW-1:0] : t[OW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      prod <= '0;
      prod_v <= 1'b0;
      acc <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      prod_v <= 1'b0;
      acc <= '0;
    end else begin
      prod_v <= accept;
      if (accept) begin
        prod <= (2*DW)'($signed(a)) * (2*DW)'($signed(b));
        cnt <= cnt + 1'b1;
      end
      if (prod_v) acc <= acc + ACCW'(prod);
    end
endmodule

// File: tb/tb_mac_dot.sv
// tb_mac_dot: directed vector bench for mac_dot (default, SHIFT=10 and ACCW=16 variants, LEN=4)
module tb_mac_dot;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [7:0] a = 0, b = 0;
  logic [7:0] res0, res1, res2;
  logic sat0, sat1, sat2, ir0, ir1, ir2, ov0, ov1, ov2, busy0, busy1, busy2;
  int checks = 0, errors = 0, cyc = 0, nacc = 0;
  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [2:0][7:0] r;
    logic [2:0] s;
  } vec_t;
  vec_t vecs[10];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && ir0) nacc <= nacc + 1;
  end
  mac_dot #(.LEN(4)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(ir0), .res(res0), .sat(sat0), .out_valid(ov0), .out_ready(out_ready), .busy(busy0));
  mac_dot #(.LEN(4), .SHIFT(10)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(ir1), .res(res1), .sat(sat1), .out_valid(ov1), .out_ready(out_ready), .busy(busy1));
  mac_dot #(.LEN(4), .ACCW(16)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(ir2), .res(res2), .sat(sat2), .out_valid(ov2), .out_ready(out_ready), .busy(busy2));
  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3, r0, s0, r1, s1, r2, s2);
    vec_t v;
    v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
    v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2); v.b[3] = 8'(b3);
    v.r[0] = 8'(r0); v.r[1] = 8'(r1); v.r[2] = 8'(r2);
    v.s[0] = 1'(s0); v.s[1] = 1'(s1); v.s[2] = 1'(s2);
    return v;
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic run(input vec_t v, input bit bub, input int hold);
    int i, n, t0, c0;
    logic rdy;
    logic [7:0] r_h;
    c0 = nacc;
    @(negedge clk); start = 1; in_valid = 1; a = 8'h55; b = 8'h55; out_ready = 0;
    @(negedge clk); t0 = cyc; start = 0;
    i = 0; n = 0;
    while (i < 4 && n < 100) begin
      if (bub && $urandom_range(0, 2) == 0) begin
        in_valid = 0; start = 1;
      end else begin
        in_valid = 1; start = 0; a = v.a[i]; b = v.b[i];
      end
      rdy = ir0;
      @(negedge clk);
      if (in_valid && rdy) i++;
      n++;
    end
    in_valid = 1; a = 8'h7f; b = 8'h7f; start = bub;
    n = 0;
    while (!ov0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid", int'(ov0), 1);
    if (!bub) chk("latency_cycle", cyc - t0 + 1, 6);
    chk("res_default", int'($signed(res0)), int'($signed(v.r[0])));
    chk("sat_default", int'(sat0), int'(v.s[0]));
    chk("res_shift10", int'($signed(res1)), int'($signed(v.r[1])));
    chk("sat_shift10", int'(sat1), int'(v.s[1]));
    chk("res_accw16", int'($signed(res2)), int'($signed(v.r[2])));
    chk("sat_accw16", int'(sat2), int'(v.s[2]));
    chk("accept_count", nacc - c0, 4);
    r_h = res0;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", int'(ov0), 1);
      chk("hold_res", int'(res0), int'(r_h));
    end
    start = 1; out_ready = 1; in_valid = 0;
    @(negedge clk); start = 0; out_ready = 0;
    chk("idle_after_handshake", int'(busy0), 0);
  endtask
  initial begin
    vecs[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 70, 0, 0, 0, 70, 0);
    vecs[1] = mk(-3, -128, 7, 0, 4, -1, -2, 9, 102, 0, 0, 0, 102, 0);
    vecs[2] = mk(-128, -128, -128, -128, -128, -128, -128, -128, 127, 1, 64, 0, 0, 0);
    vecs[3] = mk(-128, -128, -128, -128, 127, 127, 127, 127, -128, 1, -64, 0, 127, 1);
    vecs[4] = mk(127, 127, 127, 127, 127, 127, 127, 127, 127, 1, 63, 0, -128, 1);
    vecs[5] = mk(10, -20, 30, -40, 3, 3, -3, -3, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(-1, -1, -1, -1, 1, 1, 1, 1, -4, 0, -1, 0, -4, 0);
    vecs[7] = mk(127, 0, 0, 0, 1, 0, 0, 0, 127, 0, 0, 0, 127, 0);
    vecs[8] = mk(-128, -1, 0, 0, 1, 1, 0, 0, -128, 1, -1, 0, -128, 1);
    vecs[9] = mk(100, 100, 100, 100, 100, 100, 100, 100, 127, 1, 39, 0, -128, 1);
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_in_ready", int'(ir0), 0);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_res", int'(res0), 0);
    chk("rst_sat", int'(sat0), 0);
    rst_n = 1;
    for (int k = 0; k < 10; k++) run(vecs[k], 0, 0);
    run(vecs[0], 1, 5);
    run(vecs[3], 1, 2);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; in_valid = 1; a = 8'd50; b = 8'd50;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_in_ready", int'(ir0), 0);
    chk("midrst_out_valid", int'(ov0), 0);
    chk("midrst_res", int'(res0), 0);
    chk("midrst_sat", int'(sat0), 0);
    @(negedge clk); rst_n = 1; in_valid = 0;
    run(vecs[1], 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_dot.md
# mac_dot

Parametrised signed dot-product engine. It is the sequenced successor to the single-cycle multiply-accumulator. After a `start` pulse, it accepts exactly `LEN` operand pairs over a valid/ready stream and multiplies them through a registered product stage. It accumulates into an `ACCW`-bit wrapping accumulator, then presents a shifted, saturated `OW`-bit result on a valid/ready output port. It sits between the operand-fetch sequencer and the activation/writeback logic.

## Interface
- `DW`, default 8: signed width of operands `a` and `b`.
- `ACCW`, default 26: accumulator width. Must be ≥ 2·DW.
- `LEN`, default 8: operand pairs per dot product. Must be ≥ 1.
- `SHIFT`, default 0: arithmetic right shift applied to the accumulator before output saturation. Must be 0..ACCW-1.
- `OW`, default 8: signed output width. Must be ≤ ACCW.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a new dot product. Honoured only in IDLE.
- `a`, in, DW: signed operand.
- `b`, in, DW: signed operand.
- `in_valid`, in, 1: `a`/`b` valid.
- `in_ready`, out, 1: block accepts an operand pair this cycle.
- `res`, out, OW: signed saturated result.
- `sat`, out, 1: `res` was clamped.
- `out_valid`, out, 1: `res`/`sat` valid.
- `out_ready`, in, 1: consumer takes the result.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- Transitions:
  - IDLE → ACCUM on `start`. On that edge: acc cleared to 0, element counter to 0, product-valid flag to 0.
  - ACCUM → DRAIN on the edge where the LEN-th pair is accepted.
  - DRAIN → DONE after exactly one cycle.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = 1 only in ACCUM. A pair is accepted when `in_valid && in_ready`.
- Product stage:
  - On each accept, `prod <= signed(a) * signed(b)` (2·DW bits) and `prod_v <= 1`.
  - Otherwise `prod_v <= 0`.
  - When `prod_v` = 1: `acc <= acc + sext(prod)` to ACCW bits.
  - The accumulator wraps modulo 2^ACCW. There is no internal saturation.
- Output stage (combinational from acc, held stable throughout DONE):
  - `t = acc >>> SHIFT` (arithmetic shift).
  - If t > 2^(OW-1)-1: `res` = max positive, `sat` = 1.
  - If t < -2^(OW-1): `res` = min negative, `sat` = 1.
  - Otherwise `res = t[OW-1:0]`, `sat` = 0.
- `out_valid` = 1 only in DONE. `res`/`sat` are don't-care outside DONE.
- Boundary conditions:
  - `start` in ACCUM, DRAIN or DONE: ignored.
  - `in_valid` outside ACCUM: ignored, no accept.
  - `start` and `in_valid` in the same IDLE cycle: only `start` takes effect. The first accept can occur in the next cycle.
  - `in_valid` gaps (bubbles) in ACCUM: the counter holds and nothing is added.
  - `out_ready` low in DONE: the block stays in DONE with `res`, `sat` and `out_valid` held.
  - `start` in the same cycle as the DONE handshake: ignored, because the FSM is not yet in IDLE.
  - LEN = 1: a single accept goes straight to DRAIN.
- Reset, asynchronous and usable at any time including mid-operation:
  - State → IDLE; acc, prod, prod_v and the counter → 0.
  - Outputs: `in_ready` = 0, `out_valid` = 0, `busy` = 0.
  - `res` = 0 and `sat` = 0 (acc is 0).

## Timing
- `start` sampled at edge 0: ACCUM from cycle 1, `in_ready` high in cycle 1.
- Continuous `in_valid`:
  - Accepts occur in cycles 1..LEN; the product of the accept in cycle k is added at the end of cycle k+1.
  - DRAIN is cycle LEN+1.
  - `out_valid` rises in cycle LEN+2.
- With `out_ready` held high, the result is taken in cycle LEN+2 and the FSM is in IDLE at cycle LEN+3. A new `start` is honoured from cycle LEN+3.
- Minimum start-to-start period is LEN+3 cycles.
- Each cycle of `in_valid` bubbles or `out_ready` backpressure adds one cycle to the latency.
- No combinational path from `in_valid` to `in_ready`, nor from `out_ready` to `out_valid`.

## Test plan
- Basic dot product (LEN=4, defaults): a = 1,2,3,4 and b = 5,6,7,8, continuous valid → `res` = 70, `sat` = 0, `out_valid` first seen in cycle 6 after `start`.
- Negative values: a = -3,-128,7,0 and b = 4,-1,-2,9 → acc = 102, `res` = 102, `sat` = 0.
- Saturation: a = b = -128 for all 4 pairs → acc = 65536, `res` = 127, `sat` = 1. Same vectors with SHIFT=10 → `res` = 64, `sat` = 0.
  - Negative saturation: a = -128, b = 127 ×4 → `res` = -128, `sat` = 1.
- Handshake stress: random `in_valid` bubbles plus `out_ready` held low for 5 cycles in DONE → same result as the continuous run, `res` held stable, exactly LEN accepts counted, extra `start` pulses while busy ignored.
- Reset mid-operation: assert `rst_n` low after 2 accepts → immediately `busy` = 0, `in_ready` = 0, `out_valid` = 0. A subsequent full run yields the correct result with no residue from the aborted run.
- Wrap-around (ACCW=16, LEN=4): a = b = 127 ×4 → acc = 64516 mod 2^16 = -1020 → `res` = -128, `sat` = 1.
